// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu_pkg -- shared load/store encodings, FSM states, alignment helper
// Revision 1.0
// ============================================================================
package mem_stage_lsu_pkg;

  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } lsu_state_t;

  // funct3[1:0] carries the access size; any size code above half is a word.
  function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic ok;
    case (funct3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~offset[0];
      default: ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu_if -- data-memory request/response bus (valid/ready style)
// Revision 1.0
// ============================================================================
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_strb;
  logic              dmem_ready;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_strb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_strb,
    output dmem_ready, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_load_align.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu_load_align -- selects and sign/zero-extends the loaded lane
// Revision 1.0
// ============================================================================
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  wire logic [31:0] rdata_i,
  input  wire logic [1:0]  offset_i,
  input  wire logic [2:0]  funct3_i,
  output logic      [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      C_F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      C_F3_LBU: data_o = {24'd0, byte_sel};
      C_F3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      C_F3_LHU: data_o = {16'd0, half_sel};
      C_F3_LW:  data_o = rdata_i;
      default:  data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu -- MEM-stage load/store unit: bus handshake, timeout, WB bundle
// Revision 1.0
// ============================================================================
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int XLEN        = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic [XLEN-1:0] G_in,
  input  wire logic [XLEN-1:0] Data_out_in,
  input  wire logic [3:0]      STRB_in,
  input  wire logic            MW_in,
  input  wire logic            MD_in,
  input  wire logic            RW_in,
  input  wire logic [4:0]      RD_in,
  input  wire logic [2:0]      funct3_in,
  mem_stage_lsu_if.master      dmem,
  output logic                 stall,
  output logic      [XLEN-1:0] wb_data,
  output logic      [4:0]      wb_rd,
  output logic                 wb_rw,
  output logic                 misalign_err,
  output logic                 bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_t      state_q;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      strb_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            rw_q;
  logic [CNT_W-1:0] wait_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_rd_q;
  logic            wb_rw_q;
  logic            misalign_q;
  logic            bus_err_q;

  logic            memop;
  logic            aligned;
  logic            timeout_hit;
  logic [31:0]     load_val;

  assign memop   = MD_in | MW_in;
  assign aligned = addr_aligned(funct3_in, G_in[1:0]);

  generate
    if (TIMEOUT_CYC != 0) begin : g_timeout
      assign timeout_hit = (wait_q == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  mem_stage_lsu_load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (off_q),
    .funct3_i (funct3_q),
    .data_o   (load_val)
  );

  // Stall is forced low while reset is held so every output reads 0 in reset.
  assign stall = reset & (((state_q == S_IDLE) & memop) | (state_q == S_REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= 4'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= 5'd0;
      rw_q       <= 1'b0;
      wait_q     <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!memop) begin
            wb_data_q <= G_in;
            wb_rd_q   <= RD_in;
            wb_rw_q   <= RW_in;
          end else if (!aligned) begin
            misalign_q <= 1'b1;
            wb_rw_q    <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            addr_q   <= {G_in[XLEN-1:2], 2'b00};
            wdata_q  <= Data_out_in;
            strb_q   <= MW_in ? STRB_in : 4'd0;
            we_q     <= MW_in;
            funct3_q <= funct3_in;
            off_q    <= G_in[1:0];
            rd_q     <= RD_in;
            rw_q     <= RW_in;
            wait_q   <= '0;
            req_q    <= 1'b1;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          // A response arriving on the last allowed cycle still completes.
          if (dmem.dmem_ready) begin
            req_q <= 1'b0;
            if (!we_q) begin
              wb_data_q <= load_val;
              wb_rd_q   <= rd_q;
              wb_rw_q   <= rw_q;
            end else begin
              wb_rw_q <= 1'b0;
            end
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            wb_rw_q   <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_strb  = strb_q;

  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_rw        = wb_rw_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_lsu -- directed vector table, corner sequences and random ops
// Revision 1.0
// ============================================================================
module tb_mem_stage_lsu;

  localparam int TO = 16;
  localparam int NV = 14;

  typedef struct {
    logic [31:0] g;
    logic        md;
    logic        mw;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    int          waits;   // ready on this REQ cycle index; -1 = never
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_data;
    logic        exp_rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] G_in, Data_out_in;
  logic [3:0]  STRB_in;
  logic        MW_in, MD_in, RW_in;
  logic [4:0]  RD_in;
  logic [2:0]  funct3_in;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rw, misalign_err, bus_err;

  mem_stage_lsu_if #(.XLEN(32)) bus ();

  mem_stage_lsu #(.TIMEOUT_CYC(TO), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .G_in         (G_in),
    .Data_out_in  (Data_out_in),
    .STRB_in      (STRB_in),
    .MW_in        (MW_in),
    .MD_in        (MD_in),
    .RW_in        (RW_in),
    .RD_in        (RD_in),
    .funct3_in    (funct3_in),
    .dmem         (bus),
    .stall        (stall),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_rw        (wb_rw),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the WB bundle and bus registers should currently hold.
  logic [31:0] m_data, m_addr, m_wdata;
  logic [4:0]  m_rd;
  logic [3:0]  m_strb;
  logic        m_rw, m_we;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_bus(input string tag, input logic exp_req);
    chk({tag, "_req"},   32'(bus.dmem_req),  32'(exp_req));
    chk({tag, "_addr"},  bus.dmem_addr,      m_addr);
    chk({tag, "_wdata"}, bus.dmem_wdata,     m_wdata);
    chk({tag, "_strb"},  32'(bus.dmem_strb), 32'(m_strb));
    chk({tag, "_we"},    32'(bus.dmem_we),   32'(m_we));
  endtask

  task automatic check_wb(input string tag);
    chk({tag, "_wb_data"}, wb_data,      m_data);
    chk({tag, "_wb_rd"},   32'(wb_rd),   32'(m_rd));
    chk({tag, "_wb_rw"},   32'(wb_rw),   32'(m_rw));
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] o,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic op_t mk(input logic [31:0] g, input logic md, input logic mw,
                             input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                             input int waits, input logic [31:0] rdata,
                             input logic [31:0] wdata, input logic [3:0] strb);
    op_t o;
    o.g = g; o.md = md; o.mw = mw; o.rw = rw; o.rd = rd; o.f3 = f3;
    o.waits = waits; o.rdata = rdata; o.wdata = wdata; o.strb = strb;
    return o;
  endfunction

  task automatic drive_bubble();
    G_in = 32'd0; Data_out_in = 32'd0; STRB_in = 4'd0;
    MW_in = 1'b0; MD_in = 1'b0; RW_in = 1'b0; RD_in = 5'd0; funct3_in = 3'd0;
  endtask

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_op(input op_t op);
    logic memop, done_ok;
    int   size;
    memop = op.md | op.mw;
    G_in = op.g; Data_out_in = op.wdata; STRB_in = op.strb;
    MW_in = op.mw; MD_in = op.md; RW_in = op.rw; RD_in = op.rd; funct3_in = op.f3;
    bus.dmem_ready = 1'b0;
    #1;
    chk("stall_issue", 32'(stall), 32'(memop));
    if (!memop) begin
      m_data = op.g; m_rd = op.rd; m_rw = op.rw;
      @(negedge clk);
      check_wb("alu");
      check_bus("alu", 1'b0);
      chk("alu_misalign", 32'(misalign_err), 32'd0);
      chk("alu_bus_err",  32'(bus_err),      32'd0);
      return;
    end
    size = (op.f3[1:0] == 2'b00) ? 1 : (op.f3[1:0] == 2'b01) ? 2 : 4;
    if ((op.g % size) != 0) begin
      m_rw = 1'b0;
      @(negedge clk);
      chk("mis_pulse",   32'(misalign_err), 32'd1);
      chk("mis_bus_err", 32'(bus_err),      32'd0);
      chk("mis_stall",   32'(stall),        32'd0);
      check_bus("mis", 1'b0);
      check_wb("mis");
      @(negedge clk);
      chk("mis_pulse_end", 32'(misalign_err), 32'd0);
      check_bus("mis_after", 1'b0);
      return;
    end
    m_addr = op.g & 32'hFFFF_FFFC; m_wdata = op.wdata;
    m_strb = op.mw ? op.strb : 4'd0; m_we = op.mw;
    done_ok = 1'b0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      check_bus("req", 1'b1);
      if (c == op.waits) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = op.rdata;
      end
      #1;
      chk("req_stall", 32'(stall), 32'd1);
      if (c == op.waits) begin
        done_ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = $urandom;
    if (done_ok && !op.mw) begin
      m_data = ext_load(op.rdata, op.g[1:0], op.f3);
      m_rd = op.rd; m_rw = op.rw;
    end else begin
      m_rw = 1'b0;
    end
    chk("done_bus_err",  32'(bus_err),      32'(!done_ok));
    chk("done_misalign", 32'(misalign_err), 32'd0);
    chk("done_stall",    32'(stall),        32'd0);
    check_bus("done", 1'b0);
    check_wb("done");
    // Op inputs are still applied during DONE; no second request may follow.
    @(negedge clk);
    chk("post_bus_err", 32'(bus_err), 32'd0);
    check_bus("post", 1'b0);
    check_wb("post");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{mk(32'h0000_1234, 0, 0, 1, 5'd5,  3'b000, 0,  32'h0,         32'h0, 4'h0), 32'h0000_1234, 1'b1};
    vecs[1]  = '{mk(32'h0000_0103, 1, 0, 1, 5'd7,  3'b000, 0,  32'h80FF_0000, 32'h0, 4'h0), 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{mk(32'h0000_0200, 0, 1, 1, 5'd8,  3'b010, 3,  32'h0, 32'hDEAD_BEEF, 4'hF), 32'hFFFF_FF80, 1'b0};
    vecs[3]  = '{mk(32'h0000_0101, 1, 0, 1, 5'd9,  3'b001, 0,  32'h0,         32'h0, 4'h0), 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{mk(32'h0000_0300, 1, 0, 1, 5'd10, 3'b010, -1, 32'h0,         32'h0, 4'h0), 32'hFFFF_FF80, 1'b0};
    vecs[5]  = '{mk(32'h0000_0102, 1, 0, 1, 5'd11, 3'b100, 1,  32'h12AB_3456, 32'h0, 4'h0), 32'h0000_00AB, 1'b1};
    vecs[6]  = '{mk(32'h0000_0102, 1, 0, 1, 5'd12, 3'b101, 2,  32'h8001_7FFF, 32'h0, 4'h0), 32'h0000_8001, 1'b1};
    vecs[7]  = '{mk(32'h0000_0002, 1, 0, 1, 5'd13, 3'b001, 0,  32'h8001_7FFF, 32'h0, 4'h0), 32'hFFFF_8001, 1'b1};
    vecs[8]  = '{mk(32'h0000_0004, 1, 0, 1, 5'd14, 3'b111, 0,  32'hCAFE_F00D, 32'h0, 4'h0), 32'hCAFE_F00D, 1'b1};
    vecs[9]  = '{mk(32'h0000_0102, 1, 0, 1, 5'd15, 3'b010, 0,  32'h0,         32'h0, 4'h0), 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{mk(32'h0000_0010, 1, 0, 1, 5'd16, 3'b010, 15, 32'h1122_3344, 32'h0, 4'h0), 32'h1122_3344, 1'b1};
    vecs[11] = '{mk(32'hFFFF_FFFF, 0, 0, 0, 5'd31, 3'b000, 0,  32'h0,         32'h0, 4'h0), 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{mk(32'h0000_0001, 1, 0, 1, 5'd17, 3'b000, 0,  32'h0000_7F00, 32'h0, 4'h0), 32'h0000_007F, 1'b1};
    vecs[13] = '{mk(32'h0000_0003, 0, 1, 1, 5'd18, 3'b000, 1,  32'h0, 32'hAA00_0000, 4'h8), 32'h0000_007F, 1'b0};

    reset = 1'b0;
    drive_bubble();
    MD_in = 1'b1;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'h0;
    m_data = 0; m_rd = 0; m_rw = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_we = 0;
    repeat (2) @(negedge clk);
    check_wb("reset");
    check_bus("reset", 1'b0);
    chk("reset_stall",    32'(stall),        32'd0);
    chk("reset_misalign", 32'(misalign_err), 32'd0);
    chk("reset_bus_err",  32'(bus_err),      32'd0);
    drive_bubble();
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op);
      chk($sformatf("vec%0d_data", i), wb_data,     vecs[i].exp_data);
      chk($sformatf("vec%0d_rw", i),   32'(wb_rw),  32'(vecs[i].exp_rw));
    end

    // Reset landing in the middle of an access.
    G_in = 32'h40; MD_in = 1'b1; MW_in = 1'b0; RW_in = 1'b1; RD_in = 5'd3; funct3_in = 3'b010;
    @(negedge clk);
    chk("rst_req_before", 32'(bus.dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    m_data = 0; m_rd = 0; m_rw = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_we = 0;
    check_bus("rst_mid", 1'b0);
    check_wb("rst_mid");
    chk("rst_mid_stall", 32'(stall), 32'd0);
    drive_bubble();
    @(negedge clk);
    reset = 1'b1;
    run_op(mk(32'h0000_A5A5, 0, 0, 1, 5'd9, 3'b000, 0, 32'h0, 32'h0, 4'h0));
    chk("rst_alu_data", wb_data, 32'h0000_A5A5);

    for (int n = 0; n < 200; n++) begin
      op_t o;
      int  kind, r, size;
      kind = $urandom_range(0, 2);
      o = mk($urandom, kind == 1, kind == 2, 1'(($urandom_range(0, 3)) != 0),
             5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0, $urandom,
             $urandom, 4'($urandom_range(0, 15)));
      if (kind == 2) o.f3 = 3'($urandom_range(0, 2));
      size = (o.f3[1:0] == 2'b00) ? 1 : (o.f3[1:0] == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) o.g = o.g & ~(32'(size) - 32'd1);
      r = $urandom_range(0, 19);
      if (r < 16)       o.waits = r % 5;
      else if (r == 16) o.waits = TO - 1;
      else if (r == 17) o.waits = TO - 2;
      else              o.waits = -1;
      run_op(o);
    end

    drive_bubble();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
